// File: rtl/flash_therm_encoder_if.sv
// Result-side bus of the flash thermometer encoder: code, flags and handshake.
// Latency: n/a (wires only).
// Backpressure: code_ready from the consumer; overrun/clr_ovr report and clear drops.
interface flash_therm_encoder_if #(
    parameter int BITS = 3
);
    logic [BITS-1:0] code_out;
    logic            code_valid;
    logic            code_ready;
    logic            full_scale;
    logic            no_hit;
    logic            overrun;
    logic            clr_ovr;

    modport master (
        output code_out,
        output code_valid,
        output full_scale,
        output no_hit,
        output overrun,
        input  code_ready,
        input  clr_ovr
    );

    modport slave (
        input  code_out,
        input  code_valid,
        input  full_scale,
        input  no_hit,
        input  overrun,
        output code_ready,
        output clr_ovr
    );
endinterface

// File: rtl/flash_therm_encoder.sv
// Synchronises a flash-ADC thermometer word, bubble-corrects, priority-encodes and optionally averages it.
// Latency: strobe edge k -> result after edge k+1 (no averaging) or k+2 after the final averaged strobe.
// Backpressure: one-deep output register; a result arriving while held and not accepted is dropped and sets sticky overrun.
module flash_therm_encoder #(
    parameter int BITS        = 3,
    parameter int SYNC_STAGES = 2,
    parameter int BUBBLE_FIX  = 1,
    parameter int AVG_LOG2    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2**BITS-1:0]   therm_in,
    input  logic                 sample_en,
    flash_therm_encoder_if.master res
);
    localparam int W = 2**BITS;

    // Synchroniser chain; the last stage is the sampled word.
    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] s;

    // Shift the raw comparator word through the synchroniser every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= therm_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Below bit 0 the ladder is implicitly exceeded, above the top it is not.
    logic [W+1:0] s_ext;
    logic [W-1:0] c;

    assign s_ext = {1'b0, s, 1'b1};

    // Three-input majority over each bit and its neighbours removes single-bit bubbles.
    always_comb begin
        c = s;
        if (BUBBLE_FIX != 0) begin
            for (int i = 0; i < W; i++) begin
                c[i] = (s_ext[i] & s_ext[i+1]) | (s_ext[i] & s_ext[i+2]) | (s_ext[i+1] & s_ext[i+2]);
            end
        end
    end

    // Priority encode: index of the highest set bit, 0 when nothing is set.
    logic [BITS-1:0] enc_code;
    always_comb begin
        enc_code = '0;
        for (int i = 0; i < W; i++) begin
            if (c[i]) enc_code = BITS'(i);
        end
    end

    // Stage E: capture one conversion per strobe.
    logic            e_vld;
    logic [BITS-1:0] e_code;
    logic            e_full;
    logic            e_nohit;

    // Register the encoded conversion and its flags when sample_en is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_vld   <= 1'b0;
            e_code  <= '0;
            e_full  <= 1'b0;
            e_nohit <= 1'b0;
        end else begin
            e_vld <= sample_en;
            if (sample_en) begin
                e_code  <= enc_code;
                e_full  <= c[W-1];
                e_nohit <= ~|c;
            end
        end
    end

    // Result presented to the output register.
    logic            r_vld;
    logic [BITS-1:0] r_code;
    logic            r_full;
    logic            r_nohit;

    if (AVG_LOG2 == 0) begin : g_pass
        assign r_vld   = e_vld;
        assign r_code  = e_code;
        assign r_full  = e_full;
        assign r_nohit = e_nohit;
    end else begin : g_avg
        // Worst case sum is 2**AVG_LOG2 * (2**BITS - 1), which fits this width.
        logic [BITS+AVG_LOG2-1:0] acc;
        logic [BITS+AVG_LOG2-1:0] sum;
        logic [AVG_LOG2-1:0]      cnt;
        logic                     a_vld;
        logic [BITS-1:0]          a_code;
        logic                     a_full;
        logic                     a_nohit;

        assign sum = acc + {{AVG_LOG2{1'b0}}, e_code};

        // Accumulate conversions; on the last one emit the truncated mean and restart.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc     <= '0;
                cnt     <= '0;
                a_vld   <= 1'b0;
                a_code  <= '0;
                a_full  <= 1'b0;
                a_nohit <= 1'b0;
            end else begin
                a_vld <= 1'b0;
                if (e_vld) begin
                    if (&cnt) begin
                        a_vld   <= 1'b1;
                        a_code  <= BITS'(sum >> AVG_LOG2);
                        a_full  <= e_full;
                        a_nohit <= e_nohit;
                        acc     <= '0;
                        cnt     <= '0;
                    end else begin
                        acc <= sum;
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end

        assign r_vld   = a_vld;
        assign r_code  = a_code;
        assign r_full  = a_full;
        assign r_nohit = a_nohit;
    end

    // Output holding register.
    logic            o_vld;
    logic [BITS-1:0] o_code;
    logic            o_full;
    logic            o_nohit;
    logic            o_ovr;

    // Load when empty or being drained; otherwise drop the new result and flag it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_vld   <= 1'b0;
            o_code  <= '0;
            o_full  <= 1'b0;
            o_nohit <= 1'b0;
            o_ovr   <= 1'b0;
        end else begin
            if (r_vld && (!o_vld || res.code_ready)) begin
                o_vld   <= 1'b1;
                o_code  <= r_code;
                o_full  <= r_full;
                o_nohit <= r_nohit;
            end else if (!r_vld && o_vld && res.code_ready) begin
                o_vld <= 1'b0;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (r_vld && o_vld && !res.code_ready) begin
                o_ovr <= 1'b1;
            end else if (res.clr_ovr) begin
                o_ovr <= 1'b0;
            end
        end
    end

    assign res.code_out   = o_code;
    assign res.code_valid = o_vld;
    assign res.full_scale = o_full;
    assign res.no_hit     = o_nohit;
    assign res.overrun    = o_ovr;
endmodule
